// File: rtl/data_bus_bridge.sv
// Data-side bridge from the MEM stage request port to the SRAM-like req/addr_ok/data_ok bus.
// Optional feature: define DBRIDGE_WBUF_EN for a one-entry posted write buffer.
module data_bus_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                cpu_clk_50M,
    input  logic                cpu_rst,
    input  logic                dce,
    input  logic [ADDR_W-1:0]   daddr,
    input  logic [DATA_W/8-1:0] we,
    input  logic [DATA_W/8-1:0] dre,
    input  logic [DATA_W-1:0]   din,
    output logic                mem_data_ok,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                data_req,
    output logic                data_wr,
    output logic [1:0]          data_size,
    output logic [ADDR_W-1:0]   data_addr,
    output logic [DATA_W/8-1:0] data_wstrb,
    output logic [DATA_W-1:0]   data_wdata,
    input  logic                data_addr_ok,
    input  logic                data_data_ok,
    input  logic [DATA_W-1:0]   data_rdata
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic              is_store;
    logic [BE_W-1:0]   op_en;
    logic [1:0]        op_size;
    logic [ADDR_W-1:0] phys_addr;
    logic              capture;
    logic              post_store;
    logic              drain_req_next;

    // Access size from the number of active byte enables; no enables means a word load.
    function automatic logic [1:0] size_of(input logic [BE_W-1:0] en);
        int n;
        n = 0;
        for (int i = 0; i < BE_W; i++) begin
            n = n + int'(en[i]);
        end
        if (n == 1) return 2'd0;
        if (n == 2 || n == 3) return 2'd1;
        return 2'd2;
    endfunction

    assign is_store = (we != '0);
    assign op_en    = is_store ? we : dre;
    assign op_size  = size_of(op_en);

    always_comb begin
        phys_addr = daddr;
        if (daddr[ADDR_W-1 -: 2] == 2'b10) begin
            phys_addr = {3'b000, daddr[ADDR_W-4:0]};
        end
    end

`ifdef DBRIDGE_WBUF_EN
    // The bus registers double as the buffer entry; a store finishes for the MEM stage
    // as soon as it is captured and drains on its own through this small sequencer.
    typedef enum logic [1:0] {D_IDLE, D_REQ, D_WAIT} drain_t;

    drain_t drain;
    drain_t drain_next;
    logic   wbuf_valid;

    assign wbuf_valid     = (drain != D_IDLE);
    assign capture        = (state == S_IDLE) && dce && !wbuf_valid;
    assign post_store     = capture && is_store;
    assign drain_req_next = (drain_next == D_REQ);

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            drain <= D_IDLE;
        end else begin
            drain <= drain_next;
        end
    end

    always_comb begin
        drain_next = drain;
        case (drain)
            D_IDLE:  if (post_store)   drain_next = D_REQ;
            D_REQ:   if (data_addr_ok) drain_next = D_WAIT;
            D_WAIT:  if (data_data_ok) drain_next = D_IDLE;
            default: drain_next = D_IDLE;
        endcase
    end
`else
    assign capture        = (state == S_IDLE) && dce;
    assign post_store     = 1'b0;
    assign drain_req_next = 1'b0;
`endif

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (capture)      state_next = post_store ? S_DONE : S_REQ;
            S_REQ:   if (data_addr_ok) state_next = S_WAIT;
            S_WAIT:  if (data_data_ok) state_next = S_DONE;
            S_DONE:                    state_next = S_IDLE;
            default:                   state_next = S_IDLE;
        endcase
    end

    // All bus and MEM-side outputs are registered off the next state so they glitch-free track it.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            mem_data_ok <= 1'b0;
            mem_rdata   <= '0;
            data_req    <= 1'b0;
            data_wr     <= 1'b0;
            data_size   <= 2'd0;
            data_addr   <= '0;
            data_wstrb  <= '0;
            data_wdata  <= '0;
        end else begin
            mem_data_ok <= (state_next == S_DONE);
            data_req    <= (state_next == S_REQ) || drain_req_next;
            if (capture) begin
                data_addr  <= phys_addr;
                data_wr    <= is_store;
                data_size  <= op_size;
                data_wstrb <= we;
                data_wdata <= din;
            end
            if (state == S_WAIT && data_data_ok && !data_wr) begin
                mem_rdata <= data_rdata;
            end
        end
    end

endmodule

// File: tb/tb_data_bus_bridge.sv
// Scoreboard bench for data_bus_bridge: directed requests against a programmable bus responder.
// Expected store latencies switch with DBRIDGE_WBUF_EN.
module tb_data_bus_bridge;

`ifdef DBRIDGE_WBUF_EN
    localparam bit WBUF = 1'b1;
`else
    localparam bit WBUF = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        dce;
    logic [31:0] daddr;
    logic [3:0]  we;
    logic [3:0]  dre;
    logic [31:0] din;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    data_bus_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .cpu_clk_50M (clk),
        .cpu_rst     (rst),
        .dce         (dce),
        .daddr       (daddr),
        .we          (we),
        .dre         (dre),
        .din         (din),
        .mem_data_ok (mem_data_ok),
        .mem_rdata   (mem_rdata),
        .data_req    (data_req),
        .data_wr     (data_wr),
        .data_size   (data_size),
        .data_addr   (data_addr),
        .data_wstrb  (data_wstrb),
        .data_wdata  (data_wdata),
        .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .data_rdata  (data_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        int          req_len;
    } bus_exp_t;

    typedef struct {
        int          cycle;
        logic [31:0] rdata;
    } resp_exp_t;

    bus_exp_t    bus_q[$];
    resp_exp_t   resp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] model_rdata = 32'h0;

    int          addr_delay = 0;
    int          data_lat = 1;
    logic [31:0] bus_rdata = 32'h0;
    int          rphase = 0;
    int          rcnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Bus slave: addr_ok after addr_delay cycles of req, data_ok data_lat cycles after addr_ok.
    always @(negedge clk) begin
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        if (rst) begin
            rphase = 0;
            rcnt   = 0;
        end else if (rphase == 0) begin
            if (data_req) begin
                if (rcnt == addr_delay) begin
                    data_addr_ok = 1'b1;
                    rphase = 1;
                    rcnt   = 0;
                end else begin
                    rcnt++;
                end
            end
        end else begin
            rcnt++;
            if (rcnt == data_lat) begin
                data_data_ok = 1'b1;
                data_rdata   = bus_rdata;
                rphase = 0;
                rcnt   = 0;
            end
        end
    end

    // Bus monitor: compares each new request against the queue and its hold length.
    initial begin
        logic     req_prev;
        logic     cur_valid;
        logic     outstanding;
        int       req_len;
        bus_exp_t cur;
        req_prev = 1'b0; cur_valid = 1'b0; outstanding = 1'b0; req_len = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                req_prev = 1'b0; cur_valid = 1'b0; outstanding = 1'b0; req_len = 0;
            end else begin
                if (data_req && !req_prev) begin
                    checks++;
                    if (outstanding) begin
                        errors++;
                        $display("[TB] FAIL bus_overlap: got req while transaction outstanding, required none (cycle %0d)", cyc);
                    end
                    if (bus_q.size() == 0) begin
                        checks++;
                        errors++;
                        cur_valid = 1'b0;
                        $display("[TB] FAIL unexpected_req: got data_req addr 0x%08h, required none (cycle %0d)", data_addr, cyc);
                    end else begin
                        cur = bus_q.pop_front();
                        cur_valid = 1'b1;
                        check_output("data_addr", data_addr, cur.addr);
                        check_output("data_wr", data_wr, cur.wr);
                        check_output("data_size", data_size, cur.size);
                        check_output("data_wstrb", data_wstrb, cur.wstrb);
                        if (cur.wr) check_output("data_wdata", data_wdata, cur.wdata);
                    end
                    req_len = 0;
                end
                if (data_req) req_len++;
                if (!data_req && req_prev && cur_valid) begin
                    check_output("req_len", req_len, cur.req_len);
                    cur_valid = 1'b0;
                end
                if (data_req && data_addr_ok) outstanding = 1'b1;
                if (data_data_ok) outstanding = 1'b0;
                req_prev = data_req;
            end
        end
    end

    // Response monitor: every mem_data_ok pulse must match the next expected completion.
    initial begin
        resp_exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && mem_data_ok) begin
                if (resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_mem_data_ok: got pulse, required none (cycle %0d)", cyc);
                end else begin
                    e = resp_q.pop_front();
                    check_output("done_cycle", cyc, e.cycle);
                    check_output("mem_rdata", mem_rdata, e.rdata);
                end
            end
        end
    end

    // Issue one request at a falling edge and hold it until mem_data_ok (or drop it early).
    task automatic apply_stimulus(input logic [31:0] addr, input logic [3:0] we_v, input logic [3:0] dre_v,
                                  input logic [31:0] din_v, input logic [31:0] exp_addr, input logic [1:0] exp_size,
                                  input int ad, input int dl, input logic [31:0] rd, input int lat,
                                  input int drop_after);
        bus_exp_t  b;
        resp_exp_t r;
        int        n;
        addr_delay = ad;
        data_lat   = dl;
        bus_rdata  = rd;
        b.addr = exp_addr; b.wr = (we_v != 4'b0); b.size = exp_size;
        b.wstrb = we_v; b.wdata = din_v; b.req_len = ad + 1;
        bus_q.push_back(b);
        if (we_v == 4'b0) model_rdata = rd;
        r.cycle = cyc + lat;
        r.rdata = model_rdata;
        resp_q.push_back(r);
        daddr = addr; we = we_v; dre = dre_v; din = din_v; dce = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == drop_after) dce = 1'b0;
        end while (!mem_data_ok && n < 40);
        if (!mem_data_ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout: got no mem_data_ok after %0d cycles, required %0d", n, lat);
        end
        dce = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        dce = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_values();
        check_output("rst_mem_data_ok", mem_data_ok, 0);
        check_output("rst_data_req", data_req, 0);
        check_output("rst_data_wr", data_wr, 0);
        check_output("rst_data_size", data_size, 0);
        check_output("rst_data_addr", data_addr, 0);
        check_output("rst_data_wstrb", data_wstrb, 0);
        check_output("rst_data_wdata", data_wdata, 0);
        check_output("rst_mem_rdata", mem_rdata, 0);
    endtask

    initial begin
        bus_exp_t b;
        rst = 1'b1; dce = 1'b0; daddr = 32'h0; we = 4'h0; dre = 4'h0; din = 32'h0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(2);

        // Load word through kseg0, zero-wait bus
        apply_stimulus(32'h8000_0010, 4'h0, 4'hF, 32'h0, 32'h0000_0010, 2'd2, 0, 1, 32'hDEAD_BEEF, 3, 0);
        idle_cycles(3);
        // Store byte through kseg1, addr_ok delayed two cycles
        apply_stimulus(32'hBFC0_0003, 4'b0001, 4'h0, 32'h5A5A_5A5A, 32'h1FC0_0003, 2'd0, 2, 1, 32'h1111_1111,
                       WBUF ? 1 : 5, 0);
        idle_cycles(8);
        // Load half, unmapped address
        apply_stimulus(32'h0000_1002, 4'h0, 4'b0011, 32'h0, 32'h0000_1002, 2'd1, 0, 1, 32'h0000_CAFE, 3, 0);
        idle_cycles(3);
        // Load byte through kseg1 with one wait on each handshake
        apply_stimulus(32'hA000_0005, 4'h0, 4'b0010, 32'h0, 32'h0000_0005, 2'd0, 1, 2, 32'h00AB_0000, 5, 0);
        idle_cycles(3);
        // Store word through kseg0
        apply_stimulus(32'h9000_0100, 4'hF, 4'h0, 32'h1234_5678, 32'h1000_0100, 2'd2, 0, 1, 32'h2222_2222,
                       WBUF ? 1 : 3, 0);
        idle_cycles(8);
        // No enables at all: word load, kseg2 address passes through unchanged
        apply_stimulus(32'hC000_0020, 4'h0, 4'h0, 32'h0, 32'hC000_0020, 2'd2, 0, 1, 32'h0BAD_F00D, 3, 0);
        idle_cycles(3);

        // Reset while the bridge waits for data_ok: no completion may follow
        addr_delay = 0; data_lat = 5; bus_rdata = 32'h7777_7777;
        b.addr = 32'h0000_0080; b.wr = 1'b0; b.size = 2'd2; b.wstrb = 4'h0; b.wdata = 32'h0; b.req_len = 1;
        bus_q.push_back(b);
        daddr = 32'h8000_0080; we = 4'h0; dre = 4'hF; din = 32'h0; dce = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        dce = 1'b0;
        #1;
        check_reset_values();
        model_rdata = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle_cycles(6);
        apply_stimulus(32'h8000_0040, 4'h0, 4'hF, 32'h0, 32'h0000_0040, 2'd2, 0, 1, 32'h1357_9BDF, 3, 0);
        idle_cycles(3);

        // dce dropped while waiting for data_ok
        apply_stimulus(32'h0000_2000, 4'h0, 4'hF, 32'h0, 32'h0000_2000, 2'd2, 0, 3, 32'h2468_ACE0, 5, 2);
        idle_cycles(6);

        // Back-to-back loads: the second is issued during DONE and captured a cycle later
        apply_stimulus(32'h8000_0100, 4'h0, 4'hF, 32'h0, 32'h0000_0100, 2'd2, 0, 1, 32'hAAAA_0001, 3, 0);
        apply_stimulus(32'h8000_0104, 4'h0, 4'hF, 32'h0, 32'h0000_0104, 2'd2, 0, 1, 32'hAAAA_0002, 4, 0);
        idle_cycles(3);

        // Store then immediate load, bus data latency 3
        apply_stimulus(32'h8000_0200, 4'b1100, 4'h0, 32'hBEEF_0000, 32'h0000_0200, 2'd1, 0, 3, 32'h3333_3333,
                       WBUF ? 1 : 5, 0);
        apply_stimulus(32'h8000_0204, 4'h0, 4'hF, 32'h0, 32'h0000_0204, 2'd2, 0, 3, 32'h5555_AAAA,
                       WBUF ? 9 : 6, 0);
        idle_cycles(8);

        check_output("queues_empty", resp_q.size() + bus_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
